// File: rtl/parity_frame_ctrl.sv
// Framed serial parity checker: accumulates parity over DATA_BITS qualified
// data beats, compares against the trailing parity beat, and counts failures.
module parity_frame_ctrl #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 odd_sel,
  input  logic                 D_in,
  input  logic                 D_valid,
  input  logic                 abort,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 P_even,
  output logic                 done,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned      CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 odd_q;
  logic                 busy_q;
  logic                 p_even_q;
  logic                 done_q;
  logic                 ok_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                 pass_d;
  logic                 par_beat_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  // p_even_q ^ D_in is 1 when the ones count including the parity bit is even.
  always_comb begin
    pass_d     = odd_q ? ~(p_even_q ^ D_in) : (p_even_q ^ D_in);
    par_beat_d = (state_q == PAR) && !abort && D_valid;
    err_cnt_d  = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (par_beat_d && !pass_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      odd_q     <= 1'b0;
      busy_q    <= 1'b0;
      p_even_q  <= 1'b1;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      done_q    <= 1'b0;
      err_cnt_q <= err_cnt_d;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q  <= DATA;
            busy_q   <= 1'b1;
            p_even_q <= 1'b1;
            cnt_q    <= '0;
            odd_q    <= odd_sel;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        DATA: begin
          if (abort) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            p_even_q <= 1'b1;
            cnt_q    <= '0;
          end else if (D_valid) begin
            p_even_q <= p_even_q ^ D_in;
            if (cnt_q == LAST_BIT) begin
              state_q <= PAR;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        PAR: begin
          if (abort) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            p_even_q <= 1'b1;
            cnt_q    <= '0;
          end else if (D_valid) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ok_q    <= pass_d;
            err_q   <= ~pass_d;
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          p_even_q <= 1'b1;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign P_even    = p_even_q;
  assign done      = done_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Randomized bench for parity_frame_ctrl: two instances (default and 2-bit
// error counter) share stimulus and are checked against a frame-level model.
module tb_parity_frame_ctrl;

  localparam int unsigned DB = 8;

  logic CLK = 1'b0;
  logic reset, start, odd_sel, D_in, D_valid, abort, err_clr;

  logic       busy_a, pe_a, done_a, ok_a, fe_a;
  logic [7:0] cnt_a;
  logic       busy_b, pe_b, done_b, ok_b, fe_b;
  logic [1:0] cnt_b;

  int checks   = 0;
  int failures = 0;

  // frame-level model state
  int errs = 0;
  bit m_ok = 1'b0;
  bit m_err = 1'b0;
  bit m_pe = 1'b1;

  always #5 CLK = ~CLK;

  parity_frame_ctrl #(.DATA_BITS(DB), .ERR_CNT_W(8)) dut_a (
    .CLK(CLK), .reset(reset), .start(start), .odd_sel(odd_sel), .D_in(D_in),
    .D_valid(D_valid), .abort(abort), .err_clr(err_clr), .busy(busy_a),
    .P_even(pe_a), .done(done_a), .frame_ok(ok_a), .frame_err(fe_a),
    .err_count(cnt_a)
  );

  parity_frame_ctrl #(.DATA_BITS(DB), .ERR_CNT_W(2)) dut_b (
    .CLK(CLK), .reset(reset), .start(start), .odd_sel(odd_sel), .D_in(D_in),
    .D_valid(D_valid), .abort(abort), .err_clr(err_clr), .busy(busy_b),
    .P_even(pe_b), .done(done_b), .frame_ok(ok_b), .frame_err(fe_b),
    .err_count(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_all(input string tag, input bit eb, input bit ed);
    int ea, eb2;
    ea  = (errs > 255) ? 255 : errs;
    eb2 = (errs > 3) ? 3 : errs;
    check({tag, "/a.busy"},  busy_a, eb);
    check({tag, "/a.peven"}, pe_a,   m_pe);
    check({tag, "/a.done"},  done_a, ed);
    check({tag, "/a.ok"},    ok_a,   m_ok);
    check({tag, "/a.err"},   fe_a,   m_err);
    check({tag, "/a.cnt"},   cnt_a,  ea);
    check({tag, "/b.busy"},  busy_b, eb);
    check({tag, "/b.peven"}, pe_b,   m_pe);
    check({tag, "/b.done"},  done_b, ed);
    check({tag, "/b.ok"},    ok_b,   m_ok);
    check({tag, "/b.err"},   fe_b,   m_err);
    check({tag, "/b.cnt"},   cnt_b,  eb2);
  endtask

  task automatic quiet();
    reset = 1'b0; start = 1'b0; abort = 1'b0; err_clr = 1'b0;
    D_valid = 1'b0; D_in = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      D_valid = 1'($urandom); D_in = 1'($urandom); odd_sel = 1'($urandom);
      start = 1'b0; abort = 1'($urandom);
      step();
      expect_all("idle", 1'b0, 1'b0);
    end
    quiet();
  endtask

  // abort_at / reset_at: data index at which the beat is replaced (-1 = never)
  task automatic frame(input logic [DB-1:0] data, input bit p, input bit odd,
                       input int max_gap, input bit strays,
                       input int abort_at, input int reset_at, input bit clr);
    int  ones;
    int  gaps;
    bit  pass;
    ones = 0;
    start = 1'b1; odd_sel = odd; abort = 1'b0;
    D_valid = 1'($urandom); D_in = 1'($urandom);
    step();
    start = 1'b0;
    m_ok = 1'b0; m_err = 1'b0; m_pe = 1'b1;
    expect_all("start", 1'b1, 1'b0);
    for (int i = 0; i < int'(DB); i++) begin
      gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
        D_valid = 1'b0; D_in = 1'($urandom); odd_sel = 1'($urandom);
        start = strays ? 1'($urandom) : 1'b0;
        step();
        expect_all("gap", 1'b1, 1'b0);
      end
      start = strays ? 1'($urandom) : 1'b0;
      odd_sel = 1'($urandom);
      if (i == abort_at) begin
        abort = 1'b1; D_valid = 1'b1; D_in = 1'($urandom);
        step();
        quiet();
        m_pe = 1'b1;
        expect_all("abort", 1'b0, 1'b0);
        step();
        expect_all("abort+1", 1'b0, 1'b0);
        return;
      end
      if (i == reset_at) begin
        reset = 1'b1; D_valid = 1'b1; D_in = 1'($urandom);
        step();
        quiet();
        errs = 0; m_ok = 1'b0; m_err = 1'b0; m_pe = 1'b1;
        expect_all("reset", 1'b0, 1'b0);
        return;
      end
      D_valid = 1'b1; D_in = data[i];
      step();
      if (data[i]) ones++;
      m_pe = ((ones % 2) == 0);
      expect_all("data", 1'b1, 1'b0);
    end
    gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int g = 0; g < gaps; g++) begin
      D_valid = 1'b0; D_in = 1'($urandom); odd_sel = 1'($urandom);
      start = strays ? 1'($urandom) : 1'b0;
      step();
      expect_all("pgap", 1'b1, 1'b0);
    end
    start = strays ? 1'($urandom) : 1'b0;
    D_valid = 1'b1; D_in = p; err_clr = clr;
    step();
    quiet();
    pass = odd ? (((ones + int'(p)) % 2) == 1) : (((ones + int'(p)) % 2) == 0);
    m_ok = pass; m_err = !pass;
    if (clr) errs = 0;
    else if (!pass) errs++;
    expect_all("parity", 1'b0, 1'b1);
  endtask

  localparam logic [DB-1:0] D4ONES = 8'b0100_1101; // 1,0,1,1,0,0,1,0 first-bit at [0]
  localparam logic [DB-1:0] D3ONES = 8'b0000_0111; // 1,1,1,0,0,0,0,0

  initial begin
    quiet();
    odd_sel = 1'b0;
    reset = 1'b1;
    step();
    expect_all("reset0", 1'b0, 1'b0);
    step();
    reset = 1'b0;

    // directed, gap-free
    frame(D4ONES, 1'b0, 1'b0, 0, 1'b0, -1, -1, 1'b0);
    frame(D4ONES, 1'b1, 1'b0, 0, 1'b0, -1, -1, 1'b0);
    frame('0,     1'b0, 1'b0, 0, 1'b0, -1, -1, 1'b0);
    frame(D3ONES, 1'b0, 1'b1, 0, 1'b0, -1, -1, 1'b0);
    frame(D3ONES, 1'b1, 1'b1, 0, 1'b0, -1, -1, 1'b0);
    idle_cycles(3);

    // same frames with gaps and stray starts
    frame(D4ONES, 1'b0, 1'b0, 3, 1'b1, -1, -1, 1'b0);
    frame(D4ONES, 1'b1, 1'b0, 3, 1'b1, -1, -1, 1'b0);
    frame(D3ONES, 1'b0, 1'b1, 3, 1'b1, -1, -1, 1'b0);
    frame(D3ONES, 1'b1, 1'b1, 3, 1'b1, -1, -1, 1'b0);

    // abort after bit 4, then a good frame
    frame(D4ONES, 1'b0, 1'b0, 0, 1'b0, 4, -1, 1'b0);
    frame(D4ONES, 1'b0, 1'b0, 0, 1'b0, -1, -1, 1'b0);

    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1; odd_sel = 1'b0;
    step();
    quiet();
    expect_all("idle_abort", 1'b0, 1'b0);

    // reset mid-frame
    frame(D4ONES, 1'b1, 1'b0, 1, 1'b0, -1, 5, 1'b0);
    idle_cycles(2);

    // saturation on the 2-bit counter, then clear on a bad parity beat
    err_clr = 1'b1;
    step();
    quiet();
    errs = 0;
    expect_all("errclr", 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) frame(D4ONES, 1'b1, 1'b0, 0, 1'b0, -1, -1, 1'b0);
    frame(D4ONES, 1'b1, 1'b0, 0, 1'b0, -1, -1, 1'b1);

    // random frames
    for (int n = 0; n < 40; n++) begin
      int ab;
      ab = (($urandom % 8) == 0) ? int'($urandom_range(DB - 1, 0)) : -1;
      frame(DB'($urandom), 1'($urandom), 1'($urandom), 3, 1'b1, ab, -1, 1'b0);
      if (($urandom % 4) == 0) idle_cycles(int'($urandom_range(3, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
